// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array processing elements.
// Operand/product widths and the PE accumulator state encoding.
package sa_pkg;

    localparam int PE_W   = 2;
    localparam int PROD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/sa_pe_acc_vedic.sv
// 2-bit unsigned vedic (urdhva-tiryagbhyam) multiplier.
// Purely combinational; four partial products and two half adders.
import sa_pkg::*;

module sa_pe_acc_vedic (
    input  logic [PE_W-1:0]   a,
    input  logic [PE_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic pp00;
    logic pp10;
    logic pp01;
    logic pp11;
    logic c1;

    assign pp00 = a[0] & b[0];
    assign pp10 = a[1] & b[0];
    assign pp01 = a[0] & b[1];
    assign pp11 = a[1] & b[1];
    assign c1   = pp10 & pp01;

    assign p[0] = pp00;
    assign p[1] = pp10 ^ pp01;
    assign p[2] = pp11 ^ c1;
    assign p[3] = pp11 & c1;

endmodule

// File: rtl/sa_pe_acc.sv
// Output-stationary PE: forwards operands east/south and accumulates
// a saturating dot product, emitting it with a one-cycle valid pulse.
import sa_pkg::*;

module sa_pe_acc #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PE_W-1:0]  a_in,
    input  logic [PE_W-1:0]  b_in,
    input  logic             last_in,
    output logic [PE_W-1:0]  a_out,
    output logic [PE_W-1:0]  b_out,
    output logic             valid_out,
    output logic             last_out,
    output logic [ACC_W-1:0] psum_out,
    output logic             psum_valid,
    output logic             sat_out,
    output logic [CNT_W-1:0] cnt_out
);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sat;

    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum;
    logic               ovf;
    logic [ACC_W-1:0]   sum_c;
    logic [CNT_W-1:0]   cnt_inc;

    sa_pe_acc_vedic u_mul (
        .a (a_out),
        .b (b_out),
        .p (prod)
    );

    // In IDLE acc and cnt are zero, so one datapath covers both states.
    assign sum     = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign ovf     = sum[ACC_W];
    assign sum_c   = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Forward register: operands and handshake move one hop per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= in_valid;
            last_out  <= last_in & in_valid;
        end
    end

    // Accumulator FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            psum_out   <= '0;
            psum_valid <= 1'b0;
            sat_out    <= 1'b0;
            cnt_out    <= '0;
        end else begin
            psum_valid <= 1'b0;
            if (valid_out) begin
                if (last_out) begin
                    psum_out   <= sum_c;
                    sat_out    <= sat | ovf;
                    cnt_out    <= cnt_inc;
                    psum_valid <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                    sat        <= 1'b0;
                    state      <= IDLE;
                end else begin
                    acc        <= sum_c;
                    cnt        <= cnt_inc;
                    sat        <= sat | ovf;
                    state      <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_pe_acc.sv
// Self-checking bench for sa_pe_acc at ACC_W=8 and ACC_W=4,
// compared every cycle against an arithmetic dot-product model.
module tb_sa_pe_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] a_in;
    logic [1:0] b_in;
    logic       last_in;

    logic [1:0] a8, b8, a4, b4;
    logic       v8, l8, v4, l4;
    logic [7:0] ps8;
    logic [3:0] ps4;
    logic       pv8, pv4, s8, s4;
    logic [3:0] c8, c4;

    int checks = 0;
    int passed = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    sa_pe_acc #(.ACC_W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .last_in(last_in),
        .a_out(a8), .b_out(b8), .valid_out(v8), .last_out(l8),
        .psum_out(ps8), .psum_valid(pv8), .sat_out(s8), .cnt_out(c8)
    );

    sa_pe_acc #(.ACC_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .last_in(last_in),
        .a_out(a4), .b_out(b4), .valid_out(v4), .last_out(l4),
        .psum_out(ps4), .psum_valid(pv4), .sat_out(s4), .cnt_out(c4)
    );

    // Model: unbounded running total and term count; clamping is
    // applied only when a result is reported.
    int total = 0, nterms = 0;
    bit p_v = 0, p_l = 0;
    int p_a = 0, p_b = 0;
    int e_a = 0, e_b = 0, e_v = 0, e_l = 0;
    int e_pv = 0, e_cnt = 0;
    int e_ps8 = 0, e_ps4 = 0, e_s8 = 0, e_s4 = 0;
    int res_tot[$];
    int res_n[$];

    always @(posedge clk) begin
        if (rst) begin
            total = 0; nterms = 0;
            p_v = 0; p_l = 0; p_a = 0; p_b = 0;
            e_a = 0; e_b = 0; e_v = 0; e_l = 0;
            e_pv = 0; e_cnt = 0;
            e_ps8 = 0; e_ps4 = 0; e_s8 = 0; e_s4 = 0;
        end else begin
            e_pv = 0;
            if (p_v) begin
                total += p_a * p_b;
                nterms++;
                if (p_l) begin
                    e_pv  = 1;
                    e_ps8 = (total > 255) ? 255 : total;
                    e_s8  = (total > 255) ? 1 : 0;
                    e_ps4 = (total > 15) ? 15 : total;
                    e_s4  = (total > 15) ? 1 : 0;
                    e_cnt = (nterms > 15) ? 15 : nterms;
                    res_tot.push_back(total);
                    res_n.push_back(nterms);
                    total = 0;
                    nterms = 0;
                end
            end
            p_v = in_valid;
            p_l = in_valid & last_in;
            p_a = a_in;
            p_b = b_in;
            e_a = a_in; e_b = b_in;
            e_v = in_valid; e_l = in_valid & last_in;
        end
    end

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d",
                      nm, $time, act, exp);
    endfunction

    // One compare process: every output of both instances, every cycle.
    always @(negedge clk) begin
        if (checking) begin
            chk("a_out8", a8, e_a);
            chk("b_out8", b8, e_b);
            chk("valid_out8", v8, e_v);
            chk("last_out8", l8, e_l);
            chk("psum_valid8", pv8, e_pv);
            chk("psum_out8", ps8, e_ps8);
            chk("sat_out8", s8, e_s8);
            chk("cnt_out8", c8, e_cnt);
            chk("a_out4", a4, e_a);
            chk("b_out4", b4, e_b);
            chk("valid_out4", v4, e_v);
            chk("last_out4", l4, e_l);
            chk("psum_valid4", pv4, e_pv);
            chk("psum_out4", ps4, e_ps4);
            chk("sat_out4", s4, e_s4);
            chk("cnt_out4", c4, e_cnt);
        end
    end

    task automatic drive(int v, int a, int b, int l);
        in_valid = v[0];
        a_in = a[1:0];
        b_in = b[1:0];
        last_in = l[0];
        @(negedge clk);
    endtask

    int pulses8 = 0;
    always @(posedge clk) if (checking && pv8 === 1'b1) pulses8++;

    initial begin
        rst = 1; in_valid = 0; a_in = 0; b_in = 0; last_in = 0;
        @(negedge clk);
        @(negedge clk);
        checking = 1;
        rst = 0;
        drive(0, 0, 0, 0);

        // basic: 9 + 6 + 1 = 16
        drive(1, 3, 3, 0);
        drive(1, 2, 3, 0);
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // bubbles: 2 + 3 = 5
        drive(1, 1, 2, 0);
        drive(0, 2, 2, 0);
        drive(0, 1, 3, 0);
        drive(1, 3, 1, 1);
        drive(0, 0, 0, 0);
        // back-to-back: 4 then 3
        drive(1, 2, 2, 1);
        drive(1, 1, 3, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // saturation on 4-bit: 18 -> 15, then 1
        drive(1, 3, 3, 0);
        drive(1, 3, 3, 1);
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // reset mid-accumulation
        drive(1, 3, 2, 0);
        drive(1, 2, 2, 0);
        rst = 1;
        drive(0, 0, 0, 0);
        rst = 0;
        chk("psum_out8_after_rst", ps8, 0);
        chk("cnt_out8_after_rst", c8, 0);
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // masked last mid-stream, 20 terms, count saturates
        for (int i = 0; i < 20; i++) begin
            if (i == 7) drive(0, 3, 3, 1);
            drive(1, 1, 1, (i == 19) ? 1 : 0);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        checking = 0;

        // Hand-computed expectations pinning the model.
        chk("num_results", res_tot.size(), 8);
        chk("dut_pulses", pulses8, 8);
        if (res_tot.size() == 8) begin
            chk("basic_sum", res_tot[0], 16);
            chk("basic_cnt", res_n[0], 3);
            chk("bubble_sum", res_tot[1], 5);
            chk("bubble_cnt", res_n[1], 2);
            chk("b2b_sum0", res_tot[2], 4);
            chk("b2b_sum1", res_tot[3], 3);
            chk("sat_sum", res_tot[4], 18);
            chk("post_sat_sum", res_tot[5], 1);
            chk("post_rst_sum", res_tot[6], 1);
            chk("post_rst_cnt", res_n[6], 1);
            chk("long_sum", res_tot[7], 20);
        end
        chk("final_psum8", ps8, 20);
        chk("final_psum4", ps4, 15);
        chk("final_sat4", s4, 1);
        chk("final_cnt8", c8, 15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sa_pe_acc.md
Name: sa_pe_acc

Overview:
- Output-stationary processing element for the systolic convolution array. It sits directly downstream of the 2-bit unsigned vedic multiplier.
- Each cycle it registers one 2-bit activation (a) and one 2-bit weight (b). It forwards both east/south with one cycle of delay.
- It multiplies the registered operands and accumulates the products into a partial sum until a term tagged last arrives. It then emits the finished dot product with a one-cycle valid pulse.

Parameters:
- ACC_W, 8, accumulator and psum_out width; legal range 4..16; saturating.
- CNT_W, 4, width of the term counter reported with each result.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, a_in/b_in/last_in carry a valid term this cycle.
- a_in, input, 2, unsigned activation from the west neighbour.
- b_in, input, 2, unsigned weight from the north neighbour.
- last_in, input, 1, final term of the current dot product; qualified by in_valid.
- a_out, output, 2, registered a_in, to the east neighbour.
- b_out, output, 2, registered b_in, to the south neighbour.
- valid_out, output, 1, registered in_valid, forwarded.
- last_out, output, 1, registered last_in, forwarded.
- psum_out, output, ACC_W, finished dot product.
- psum_valid, output, 1, single-cycle pulse; psum_out/sat_out/cnt_out valid.
- sat_out, output, 1, result saturated during this dot product.
- cnt_out, output, CNT_W, number of terms in the result (saturates at all-ones).

Behaviour:
- Reset: clk rising edge with rst=1 clears all outputs and internal state to 0. The FSM goes to IDLE. Any partial accumulation is discarded, with no psum_valid pulse.
- Stage R1 (forward register), every edge:
  - a_out<=a_in, b_out<=b_in, valid_out<=in_valid.
  - last_out<=last_in&in_valid.
  - Forward latency is exactly 1 cycle, with no dependence on FSM state.
- Product: prod = a_out*b_out, a 4-bit unsigned value from the 2x2 multiplier. It is combinational from R1 and zero-extended to ACC_W.
- Accumulate, on the edge after R1 holds a valid term: sum = acc + prod.
  - If sum > 2^ACC_W-1, clamp to 2^ACC_W-1 and set the sticky sat flag.
- FSM states: IDLE (acc=0, cnt=0, sat=0) and ACC (one or more terms held).
  - IDLE, valid_out=0: stay in IDLE.
  - IDLE, valid_out=1, last_out=0: acc<=prod, cnt<=1, go to ACC.
  - IDLE or ACC, valid_out=1, last_out=1:
    - psum_out<=sum (clamped), sat_out<=sat|overflow_now, cnt_out<=cnt+1 (saturating), psum_valid<=1.
    - acc, cnt and sat clear; go to IDLE.
    - A single-term dot product is legal.
  - ACC, valid_out=1, last_out=0: acc<=sum, cnt<=cnt+1 (saturating at 2^CNT_W-1), stay in ACC.
  - ACC, valid_out=0: hold all state. Bubbles are legal and do not end the dot product.
- Result latency: a last term sampled at edge E0 is in R1 after E0. psum_valid is high for the cycle after E1.
- psum_valid is high for exactly one cycle. psum_out, sat_out and cnt_out hold their values until the next result or reset.
- Back-to-back: the first term of the next dot product may arrive the cycle after a last term. The new accumulation starts from 0, with no loss and no merge.
- in_valid=0 with last_in=1: last is ignored (masked at R1).
- No backpressure: the consumer must accept psum_valid when it is pulsed.

Decomposition:
- Shared package (sa_pkg):
  - PE operand width constant (2).
  - Product width constant (4).
  - FSM state encoding: IDLE=1'b0, ACC=1'b1.
- Sub-module: instantiate the existing 2-bit unsigned vedic multiplier for prod. Do not write an inline '*'.
- Saturating add and count logic stay local to the block.

Test Plan:
- Basic dot product: terms (3,3),(2,3),(1,1)+last on consecutive cycles -> one psum_valid pulse, psum_out=16, cnt_out=3, sat_out=0, 2 cycles after the last input edge. a_out/b_out track inputs delayed by 1.
- Bubbles: terms (1,2), idle, idle, (3,1)+last -> psum_out=5, cnt_out=2. The FSM stays in ACC across the idles.
- Back-to-back: (2,2)+last then immediately (1,3)+last -> two consecutive pulses with psum_out=4 then 3, cnt_out=1 each.
- Saturation with ACC_W=4: (3,3),(3,3)+last -> psum_out=15, sat_out=1. The next dot product (1,1)+last gives psum_out=1, sat_out=0.
- Reset mid-accumulation: (3,2),(2,2), then rst=1 for one cycle, then (1,1)+last -> no pulse from the aborted sum, then psum_out=1, cnt_out=1. All outputs read 0 the cycle after rst.
- Masked last: in_valid=0 with last_in=1 while in ACC -> no pulse, accumulator unchanged. The count saturates at 15 after 20 terms (CNT_W=4).
